// File: rtl/shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : shift_sequencer
// Description : Loads a parallel word and shifts Len bits out serially,
//               MSB- or LSB-first, with busy/valid/done handshaking.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] Din,
  input  logic [3:0]       Len,
  input  logic             Dir,
  output logic             SerOut,
  output logic             SerValid,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Q
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_t;

  localparam logic [3:0] C_WIDTH_LEN = 4'(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic [3:0]       eff_len;

  // Zero or oversized lengths mean "shift the whole word".
  assign eff_len = ((Len == 4'd0) || (Len > C_WIDTH_LEN)) ? C_WIDTH_LEN : Len;

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          q_d     = Din;
          dir_d   = Dir;
          cnt_d   = eff_len;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        q_d   = dir_q ? {1'b0, q_q[WIDTH-1:1]} : {q_q[WIDTH-2:0], 1'b0};
        cnt_d = (cnt_q != 4'd0) ? (cnt_q - 4'd1) : 4'd0;
        if (cnt_q <= 4'd1) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(negedge Clock) begin
    if (Reset) begin
      state_q <= S_IDLE;
      q_q     <= '0;
      cnt_q   <= 4'd0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
    end
  end

  assign SerOut   = dir_q ? q_q[0] : q_q[WIDTH-1];
  assign SerValid = (state_q == S_SHIFT);
  assign Busy     = (state_q == S_SHIFT) || (state_q == S_DONE);
  assign Done     = (state_q == S_DONE);
  assign Q        = q_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_sequencer
// Description : Directed self-checking bench for shift_sequencer (WIDTH=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_sequencer;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       Start = 1'b0;
  logic [7:0] Din   = 8'h00;
  logic [3:0] Len   = 4'd0;
  logic       Dir   = 1'b0;
  logic       SerOut, SerValid, Busy, Done;
  logic [7:0] Q;

  int n_cmp = 0;
  int n_bad = 0;

  shift_sequencer #(.WIDTH(8)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Din(Din), .Len(Len),
    .Dir(Dir), .SerOut(SerOut), .SerValid(SerValid), .Busy(Busy),
    .Done(Done), .Q(Q)
  );

  always #5 Clock = ~Clock;

  // State changes on the falling edge; observe and drive 1 time unit later.
  task automatic tick();
    @(negedge Clock);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
    n_cmp++;
    if ({SerOut, SerValid, Busy, Done} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b want 0000", {SerOut, SerValid, Busy, Done});
    end
    n_cmp++;
    if (Q !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_q: got %h want 00", Q);
    end
  endtask

  task automatic test_msb_full();
    logic [7:0] exp_bits;
    exp_bits = 8'hA5;
    Din = 8'hA5; Len = 4'd8; Dir = 1'b0; Start = 1'b1;
    tick();
    Start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (SerValid !== 1'b1 || Busy !== 1'b1 || SerOut !== exp_bits[7-i]) begin
        n_bad++;
        $display("FAIL msb_bit%0d: got out=%b valid=%b busy=%b want out=%b valid=1 busy=1",
                 i, SerOut, SerValid, Busy, exp_bits[7-i]);
      end
      tick();
    end
    n_cmp++;
    if (Done !== 1'b1 || Busy !== 1'b1 || SerValid !== 1'b0 || Q !== 8'h00) begin
      n_bad++;
      $display("FAIL msb_done: got done=%b busy=%b valid=%b q=%h want 1 1 0 00",
               Done, Busy, SerValid, Q);
    end
    tick();
    n_cmp++;
    if (Done !== 1'b0 || Busy !== 1'b0) begin
      n_bad++;
      $display("FAIL msb_idle: got done=%b busy=%b want 0 0", Done, Busy);
    end
  endtask

  task automatic test_lsb_partial();
    logic [2:0] exp_bits;
    exp_bits = 3'b101;
    Din = 8'hA5; Len = 4'd3; Dir = 1'b1; Start = 1'b1;
    tick();
    Start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (SerValid !== 1'b1 || SerOut !== exp_bits[2-i]) begin
        n_bad++;
        $display("FAIL lsb_bit%0d: got out=%b valid=%b want out=%b valid=1",
                 i, SerOut, SerValid, exp_bits[2-i]);
      end
      tick();
    end
    n_cmp++;
    if (Done !== 1'b1 || SerValid !== 1'b0 || Q !== 8'h14) begin
      n_bad++;
      $display("FAIL lsb_done: got done=%b valid=%b q=%h want 1 0 14", Done, SerValid, Q);
    end
    tick();
    n_cmp++;
    if (Busy !== 1'b0 || Q !== 8'h14 || SerOut !== 1'b0) begin
      n_bad++;
      $display("FAIL lsb_idle_hold: got busy=%b q=%h out=%b want 0 14 0", Busy, Q, SerOut);
    end
  endtask

  task automatic test_len_bounds();
    logic [3:0] lens [3];
    int         exp_n [3];
    int         n;
    lens[0] = 4'd0;  exp_n[0] = 8;
    lens[1] = 4'd12; exp_n[1] = 8;
    lens[2] = 4'd1;  exp_n[2] = 1;
    for (int k = 0; k < 3; k++) begin
      Din = 8'h3C; Len = lens[k]; Dir = 1'b0; Start = 1'b1;
      tick();
      Start = 1'b0;
      n = 0;
      while (SerValid === 1'b1 && n < 20) begin
        n++;
        tick();
      end
      n_cmp++;
      if (n != exp_n[k] || Done !== 1'b1) begin
        n_bad++;
        $display("FAIL len%0d_count: got valid_cycles=%0d done=%b want %0d 1",
                 lens[k], n, Done, exp_n[k]);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_busy, exp_valid, got_busy, got_valid;
    exp_busy  = 8'b1110_1110;
    exp_valid = 8'b1100_1100;
    Din = 8'hFF; Len = 4'd2; Dir = 1'b0; Start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      got_busy[7-i]  = Busy;
      got_valid[7-i] = SerValid;
    end
    Start = 1'b0;
    tick();
    n_cmp++;
    if (got_busy !== exp_busy) begin
      n_bad++;
      $display("FAIL b2b_busy: got %b want %b", got_busy, exp_busy);
    end
    n_cmp++;
    if (got_valid !== exp_valid) begin
      n_bad++;
      $display("FAIL b2b_valid: got %b want %b", got_valid, exp_valid);
    end
  endtask

  task automatic test_reset_mid_shift();
    int n;
    Din = 8'hA5; Len = 4'd8; Dir = 1'b0; Start = 1'b1;
    tick();
    Start = 1'b0;
    tick(); tick(); tick();
    // Start held alongside reset: reset must win.
    Reset = 1'b1; Start = 1'b1;
    tick();
    n_cmp++;
    if (Q !== 8'h00 || Busy !== 1'b0 || Done !== 1'b0 || SerValid !== 1'b0) begin
      n_bad++;
      $display("FAIL midreset: got q=%h busy=%b done=%b valid=%b want 00 0 0 0",
               Q, Busy, Done, SerValid);
    end
    Reset = 1'b0;
    tick();
    Start = 1'b0;
    n_cmp++;
    if (Busy !== 1'b1 || Q !== 8'hA5) begin
      n_bad++;
      $display("FAIL post_reset_load: got busy=%b q=%h want 1 a5", Busy, Q);
    end
    n = 0;
    while (SerValid === 1'b1 && n < 20) begin
      n++;
      tick();
    end
    n_cmp++;
    if (n != 8 || Done !== 1'b1) begin
      n_bad++;
      $display("FAIL post_reset_xfer: got valid_cycles=%0d done=%b want 8 1", n, Done);
    end
    tick();
  endtask

  task automatic test_input_change();
    logic [7:0] exp_bits;
    exp_bits = 8'hA5;
    Din = 8'hA5; Len = 4'd8; Dir = 1'b0; Start = 1'b1;
    tick();
    Start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      Din = 8'($urandom);
      Len = 4'($urandom);
      Dir = ~Dir;
      n_cmp++;
      if (SerValid !== 1'b1 || SerOut !== exp_bits[7-i]) begin
        n_bad++;
        $display("FAIL chg_bit%0d: got out=%b valid=%b want out=%b valid=1",
                 i, SerOut, SerValid, exp_bits[7-i]);
      end
      tick();
    end
    n_cmp++;
    if (Done !== 1'b1 || Q !== 8'h00) begin
      n_bad++;
      $display("FAIL chg_done: got done=%b q=%h want 1 00", Done, Q);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_msb_full();
    test_lsb_partial();
    test_len_bounds();
    test_back_to_back();
    test_reset_mid_shift();
    test_input_change();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
